// File: rtl/pc_fetch_if.sv
// Bundle between the fetch unit and the rest of the datapath: instruction memory,
// control decoder flags and register-file read ports in, PC and IM address out.
interface pc_fetch_if #(
  parameter int unsigned IM_AW = 10
);
  logic [31:0]      instr;
  logic [1:0]       pc_sel;
  logic             beq;
  logic             bne;
  logic             bgez;
  logic             syscall;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      v0_data;
  logic [31:0]      a0_data;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [IM_AW-1:0] imem_addr;

  // Fetch unit side.
  modport master (
    input  instr, pc_sel, beq, bne, bgez, syscall,
    input  rs_data, rt_data, v0_data, a0_data,
    output pc, pc_plus4, imem_addr
  );

  // Datapath / decoder side.
  modport slave (
    output instr, pc_sel, beq, bne, bgez, syscall,
    output rs_data, rt_data, v0_data, a0_data,
    input  pc, pc_plus4, imem_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-PC resolution for the single-cycle MIPS core, with syscall
// halt/resume and run-statistics counters for the display.
module pc_fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int unsigned IM_AW     = 10,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              go,
  pc_fetch_if.master        bus,
  output logic              halted,
  output logic [31:0]       disp_data,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       jump_cnt,
  output logic [31:0]       br_cnt,
  output logic [31:0]       br_taken_cnt
);

  typedef enum logic {StRun, StHalt} state_e;

  localparam logic [1:0] PcSeq  = 2'b00;
  localparam logic [1:0] PcBr   = 2'b01;
  localparam logic [1:0] PcJump = 2'b10;
  localparam logic [1:0] PcJr   = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] jump_cnt_q, jump_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic        is_branch;
  logic        take;
  logic [31:0] next_pc;
  logic        halt_req;

  // Target computation
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign j_target  = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
  assign jr_target = {bus.rs_data[31:2], 2'b00};

  assign is_branch = bus.beq | bus.bne | bus.bgez;
  assign halt_req  = (bus.v0_data == HALT_CODE);

  always_comb begin
    take = 1'b0;
    if (bus.beq  && (bus.rs_data == bus.rt_data)) take = 1'b1;
    if (bus.bne  && (bus.rs_data != bus.rt_data)) take = 1'b1;
    if (bus.bgez && !bus.rs_data[31])             take = 1'b1;
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (bus.pc_sel)
      PcSeq:   next_pc = pc_plus4;
      PcBr:    next_pc = take ? br_target : pc_plus4;
      PcJump:  next_pc = j_target;
      PcJr:    next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // Next-state: everything holds unless en strobes this edge.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    disp_d         = disp_q;
    cycle_cnt_d    = cycle_cnt_q;
    jump_cnt_d     = jump_cnt_q;
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;

    if (en) begin
      unique case (state_q)
        StRun: begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
          if (bus.syscall) begin
            if (halt_req) begin
              // PC parks on the syscall; resume steps past it.
              state_d = StHalt;
            end else begin
              disp_d = bus.a0_data;
              pc_d   = pc_plus4;
            end
          end else begin
            pc_d = next_pc;
            if (bus.pc_sel[1]) begin
              jump_cnt_d = jump_cnt_q + 32'd1;
            end
            if ((bus.pc_sel == PcBr) && is_branch) begin
              br_cnt_d = br_cnt_q + 32'd1;
              if (take) begin
                br_taken_cnt_d = br_taken_cnt_q + 32'd1;
              end
            end
          end
        end
        StHalt: begin
          if (go) begin
            state_d = StRun;
            pc_d    = pc_plus4;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      pc_q           <= PC_RESET;
      disp_q         <= 32'd0;
      cycle_cnt_q    <= 32'd0;
      jump_cnt_q     <= 32'd0;
      br_cnt_q       <= 32'd0;
      br_taken_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      disp_q         <= disp_d;
      cycle_cnt_q    <= cycle_cnt_d;
      jump_cnt_q     <= jump_cnt_d;
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.imem_addr = pc_q[IM_AW+1:2];

  assign halted       = (state_q == StHalt);
  assign disp_data    = disp_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign jump_cnt     = jump_cnt_q;
  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a reference model checked every cycle, plus literal
// expectations along the instruction sequence.
module tb_pc_fetch_unit;

  localparam int unsigned IM_AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        go = 1'b0;
  logic        halted;
  logic [31:0] disp_data, cycle_cnt, jump_cnt, br_cnt, br_taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_fetch_if #(.IM_AW(IM_AW)) bus ();

  pc_fetch_unit #(
    .PC_RESET (32'h0000_0000),
    .IM_AW    (IM_AW),
    .HALT_CODE(32'd10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .go          (go),
    .bus         (bus),
    .halted      (halted),
    .disp_data   (disp_data),
    .cycle_cnt   (cycle_cnt),
    .jump_cnt    (jump_cnt),
    .br_cnt      (br_cnt),
    .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only.
  logic [31:0] m_pc = 0, m_disp = 0, m_cyc = 0, m_jmp = 0, m_br = 0, m_brt = 0;
  logic        m_halt = 0;

  function automatic logic model_take();
    return (bus.beq  && bus.rs_data == bus.rt_data) ||
           (bus.bne  && bus.rs_data != bus.rt_data) ||
           (bus.bgez && $signed(bus.rs_data) >= 0);
  endfunction

  function automatic logic [31:0] model_next_pc();
    longint seq;
    longint off;
    seq = longint'(m_pc) + 4;
    off = longint'($signed(bus.instr[15:0])) * 4;
    case (bus.pc_sel)
      2'd1:    return model_take() ? 32'(seq + off) : 32'(seq);
      2'd2:    return (32'(seq) & 32'hF000_0000) | (32'(bus.instr[25:0]) * 4);
      2'd3:    return bus.rs_data & ~32'd3;
      default: return 32'(seq);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_disp <= 0; m_cyc <= 0; m_jmp <= 0; m_br <= 0; m_brt <= 0; m_halt <= 0;
    end else if (en) begin
      if (m_halt) begin
        if (go) begin
          m_halt <= 1'b0;
          m_pc   <= m_pc + 4;
        end
      end else begin
        m_cyc <= m_cyc + 1;
        if (bus.syscall) begin
          if (bus.v0_data == 32'd10) begin
            m_halt <= 1'b1;
          end else begin
            m_disp <= bus.a0_data;
            m_pc   <= m_pc + 4;
          end
        end else begin
          m_pc <= model_next_pc();
          if (bus.pc_sel >= 2'd2) m_jmp <= m_jmp + 1;
          if (bus.pc_sel == 2'd1 && (bus.beq || bus.bne || bus.bgez)) begin
            m_br <= m_br + 1;
            if (model_take()) m_brt <= m_brt + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 4);
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[IM_AW+1:2]));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("disp_data", disp_data, m_disp);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("jump_cnt", jump_cnt, m_jmp);
    chk("br_cnt", br_cnt, m_br);
    chk("br_taken_cnt", br_taken_cnt, m_brt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set decoder/regfile inputs for the next edge.
  task automatic drive(input logic [1:0] sel, input logic [2:0] flags, input logic sys,
                       input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bus.pc_sel  = sel;
    bus.beq     = flags[2];
    bus.bne     = flags[1];
    bus.bgez    = flags[0];
    bus.syscall = sys;
    bus.instr   = ins;
    bus.rs_data = rs;
    bus.rt_data = rt;
  endtask

  initial begin
    bus.v0_data = 0;
    bus.a0_data = 0;
    drive(2'd0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset pc", bus.pc, 32'h0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq pc", bus.pc, 32'(i * 4));
    end
    chk("seq cycle_cnt", cycle_cnt, 32'd3);
    chk("seq imem_addr", 32'(bus.imem_addr), 32'd3);

    drive(2'd2, 3'b000, 1'b0, 32'h0000_0004, 32'd0, 32'd0); step();
    chk("j to 0x10", bus.pc, 32'h10);
    chk("j jump_cnt", jump_cnt, 32'd1);

    drive(2'd1, 3'b100, 1'b0, 32'h0000_FFFE, 32'd5, 32'd5); step();
    chk("beq taken pc", bus.pc, 32'h0C);
    chk("beq br_cnt", br_cnt, 32'd1);
    chk("beq br_taken_cnt", br_taken_cnt, 32'd1);
    drive(2'd1, 3'b100, 1'b0, 32'h0000_FFFE, 32'd5, 32'd6); step();
    chk("beq not taken pc", bus.pc, 32'h10);
    chk("beq nt br_cnt", br_cnt, 32'd2);
    chk("beq nt br_taken_cnt", br_taken_cnt, 32'd1);

    drive(2'd2, 3'b000, 1'b0, 32'h0000_0008, 32'd0, 32'd0); step();
    chk("j to 0x20", bus.pc, 32'h20);
    drive(2'd1, 3'b001, 1'b0, 32'h0000_0004, 32'h8000_0000, 32'd0); step();
    chk("bgez neg pc", bus.pc, 32'h24);
    chk("bgez neg br_taken_cnt", br_taken_cnt, 32'd1);
    drive(2'd1, 3'b001, 1'b0, 32'h0000_0004, 32'h0, 32'd0); step();
    chk("bgez zero pc", bus.pc, 32'h38);
    chk("bgez br_taken_cnt", br_taken_cnt, 32'd2);

    drive(2'd1, 3'b000, 1'b0, 32'h0000_0004, 32'h0, 32'h0); step();
    chk("sel01 no flag pc", bus.pc, 32'h3C);
    chk("sel01 no flag br_cnt", br_cnt, 32'd4);

    en = 1'b0;
    drive(2'd3, 3'b000, 1'b0, 32'h0, 32'h3000_0040, 32'd0); step();
    chk("en=0 hold pc", bus.pc, 32'h3C);
    chk("en=0 hold cycle_cnt", cycle_cnt, 32'd10);
    en = 1'b1;
    step();
    chk("jr pc", bus.pc, 32'h3000_0040);
    drive(2'd2, 3'b000, 1'b0, 32'h0000_0100, 32'd0, 32'd0); step();
    chk("j region pc", bus.pc, 32'h3000_0400);
    drive(2'd3, 3'b000, 1'b0, 32'h0, 32'h0000_0123, 32'd0); step();
    chk("jr low bits", bus.pc, 32'h120);
    chk("jump_cnt after jr", jump_cnt, 32'd5);

    drive(2'd2, 3'b000, 1'b0, 32'h0000_0014, 32'd0, 32'd0); step();
    chk("j to 0x50", bus.pc, 32'h50);
    bus.v0_data = 32'd1;
    bus.a0_data = 32'h0000_ABCD;
    drive(2'd0, 3'b000, 1'b1, 32'h0, 32'd0, 32'd0); step();
    chk("syscall disp", disp_data, 32'h0000_ABCD);
    chk("syscall pc", bus.pc, 32'h54);
    bus.v0_data = 32'd10;
    step();
    chk("halt flag", 32'(halted), 32'd1);
    chk("halt pc", bus.pc, 32'h54);
    chk("halt cycle_cnt", cycle_cnt, 32'd16);
    drive(2'd2, 3'b000, 1'b0, 32'h0000_0040, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("frozen pc", bus.pc, 32'h54);
    chk("frozen cycle_cnt", cycle_cnt, 32'd16);
    chk("frozen jump_cnt", jump_cnt, 32'd6);

    en = 1'b0; go = 1'b1; step();
    chk("go without en", 32'(halted), 32'd1);
    en = 1'b1; step();
    go = 1'b0;
    chk("resume pc", bus.pc, 32'h58);
    chk("resume halted", 32'(halted), 32'd0);
    chk("resume cycle_cnt", cycle_cnt, 32'd16);

    go = 1'b1;
    drive(2'd0, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0); step();
    go = 1'b0;
    chk("go in run pc", bus.pc, 32'h5C);
    drive(2'd3, 3'b000, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd0); step();
    chk("jr top pc", bus.pc, 32'hFFFF_FFFC);
    drive(2'd0, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0); step();
    chk("pc wrap", bus.pc, 32'h0);
    chk("wrap cycle_cnt", cycle_cnt, 32'd19);

    drive(2'd0, 3'b000, 1'b1, 32'h0, 32'd0, 32'd0); step();
    chk("halt again", 32'(halted), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pc", bus.pc, 32'h0);
    chk("async rst halted", 32'(halted), 32'd0);
    chk("async rst cycle_cnt", cycle_cnt, 32'd0);
    chk("async rst jump_cnt", jump_cnt, 32'd0);
    chk("async rst disp", disp_data, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
